ram_cmd_master: RTL and testbench
=================================

# ram_cmd_master

Command initiator for the dual-port RAM word protocol. It accepts high-level write/read requests on a valid/ready port and issues 10-bit command words (2-bit opcode + 8-bit payload) with `rx_valid` toward the RAM. It collects the RAM's `dout`/`tx_valid` read return and presents it as a one-cycle response. It sits on the host side of the RAM, mirroring the SPI-slave-fed path, and is used for on-chip RAM access and for driving the RAM in system test.

## Interface
- `ADDR_SIZE`, 8: address and data width; the command word is `ADDR_SIZE+2` bits.
- `TIMEOUT_CYCLES`, 64: number of cycles the block waits for `ram_tx_valid` before flagging an error (minimum 2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_SIZE: target address.
- `req_wdata` in ADDR_SIZE: write data; ignored on reads.
- `rsp_valid` out 1: one-cycle pulse when a read completes. There is no backpressure.
- `rsp_rdata` out ADDR_SIZE: read data, valid with `rsp_valid`.
- `rsp_err` out 1: read timed out, valid with `rsp_valid`.
- `ram_din` out ADDR_SIZE+2: command word `{op[1:0], payload}`.
- `ram_rx_valid` out 1: command word valid for one cycle.
- `ram_dout` in ADDR_SIZE: RAM read data.
- `ram_tx_valid` in 1: RAM read-data qualifier. Required to pulse once per `11` command.

## Operation
- **Opcodes:**
  - `00`: set write address.
  - `01`: write data.
  - `10`: set read address.
  - `11`: read; payload is 0.
- **FSM states:** IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, WAIT_RSP, RESP.
  - IDLE: `req_ready=1`. On handshake, the block captures `req_*` into registers. It moves to WR_ADDR if `req_wr`, otherwise to RD_ADDR.
  - WR_ADDR: drives `{00,addr}`, then goes to WR_DATA.
  - WR_DATA: drives `{01,wdata}`, then goes to IDLE.
  - RD_ADDR: drives `{10,addr}`, then goes to RD_CMD.
  - RD_CMD: drives `{11,0}`, clears the timeout counter, then goes to WAIT_RSP.
  - WAIT_RSP: on `ram_tx_valid`, registers `ram_dout` and sets err=0, then goes to RESP. If the counter reaches `TIMEOUT_CYCLES-1` without `ram_tx_valid`, it sets rdata=0 and err=1, then goes to RESP. Otherwise it increments the counter.
  - RESP: `rsp_valid=1` for one cycle, then goes to IDLE.
- `ram_rx_valid` is high only in WR_ADDR, WR_DATA, RD_ADDR and RD_CMD. `ram_din` is 0 whenever `ram_rx_valid` is 0.
- `ram_tx_valid` outside WAIT_RSP is ignored and does not change any state.
- If `ram_tx_valid` and the timeout arrive in the same cycle, `ram_tx_valid` wins (err=0).
- Only one request is outstanding at a time. `req_*` may change freely after the handshake.
- **Reset:** `rst` in any state, including mid-sequence, returns the FSM to IDLE and clears the counter and address caches on the next edge. The RAM must be reset by the same event.
- **Reset values:**
  - `req_ready=0` during reset, 1 in the first cycle after reset.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
  - `ram_din=0`, `ram_rx_valid=0`.

## Timing
- All outputs are registered or decoded from state. No combinational path exists from `req_*` or `ram_*` inputs to outputs.
- **Write,** handshake at cycle 0:
  - `{00,a}` in cycle 1.
  - `{01,d}` in cycle 2.
  - `req_ready=1` in cycle 3.
- **Read,** handshake at cycle 0:
  - `{10,a}` in cycle 1.
  - `{11,0}` in cycle 2.
  - WAIT_RSP from cycle 3. With a 1-cycle RAM, `ram_tx_valid` arrives in cycle 3.
  - `rsp_valid` in cycle 4, `req_ready=1` in cycle 5.
- **Timeout:** WAIT_RSP lasts exactly `TIMEOUT_CYCLES` cycles, then RESP follows.

## Configuration
- `RAM_CMD_ADDR_CACHE_EN`, defined: the block keeps `wr_addr_q`/`wr_vld_q` and `rd_addr_q`/`rd_vld_q`.
  - If the request address equals the cached address and the valid bit is set, the address word is skipped. IDLE then goes directly to WR_DATA or RD_CMD.
  - The cache is updated when the address word is issued.
  - Valid bits are cleared by `rst`.
  - Cached timings: write drives `{01,d}` in cycle 1 with ready in cycle 2; read drives `{11,0}` in cycle 1 with `rsp_valid` in cycle 3.
- Undefined: the address word is always sent, and no cache registers exist.

## Structure
- Shared package `ram_cmd_pkg` holds:
  - the opcode localparams `OP_WADDR=2'b00`, `OP_WDATA=2'b01`, `OP_RADDR=2'b10` and `OP_READ=2'b11`;
  - the FSM state enum `ram_cmd_state_t`.
- One sub-module, `ram_cmd_timeout`: a loadable counter with `clr`, `en` and `expired` signals, parameterised by `TIMEOUT_CYCLES`.
- Bench model: a behavioural RAM with 1-cycle read latency that pulses `tx_valid`.

## Test plan
- **Reset then write:** write addr 0x12, data 0xA5 → `ram_din` = 0x012 then 0x1A5 on consecutive cycles, `ram_rx_valid` high for 2 cycles, `req_ready` high again in cycle 3.
- **Read after write:** read addr 0x12 → `ram_din` = 0x212, then 0x300, then `rsp_valid` in cycle 4 with `rsp_rdata`=0xA5 and `rsp_err`=0.
- **Timeout:** bench RAM never asserts `tx_valid`, `TIMEOUT_CYCLES`=8 → `rsp_valid` in cycle 11 with `rsp_err`=1 and `rsp_rdata`=0x00.
- **Stray input:** `ram_tx_valid` pulsed while in IDLE → no `rsp_valid`; the next read still returns the correct data.
- **Reset mid-read:** `rst` asserted in WAIT_RSP → no `rsp_valid`, `ram_rx_valid`=0, and `req_ready`=1 in the first cycle after reset.
- **Cache enabled:** with the macro defined, two writes to addr 0x40 → the second write issues only 0x1xx and is accepted again 2 cycles after handshake. A write to 0x41 issues 0x041 then 0x1xx.

Source files
------------

// File: rtl/ram_cmd_pkg.sv
// Shared definitions for the RAM command initiator: opcodes and FSM states.
package ram_cmd_pkg;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_CMD,
    WAIT_RSP,
    RESP
  } ram_cmd_state_t;

endpackage

// File: rtl/ram_cmd_timeout.sv
// Read-response watchdog: clr loads zero, en counts up, expired flags the
// last allowed wait cycle (count == TIMEOUT_CYCLES-1).
module ram_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LAST);

  // Count while enabled; hold at the terminal value so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ram_cmd_master.sv
// Command initiator for the dual-port RAM word protocol. Turns write/read
// requests into {op, payload} command words and returns read data as a
// one-cycle response.
// Optional feature: define RAM_CMD_ADDR_CACHE_EN to skip the address word
// when the request address matches the last address sent for that port.
module ram_cmd_master
  import ram_cmd_pkg::*;
#(
  parameter int ADDR_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  ram_cmd_state_t       state;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic                 tmo_expired;
  logic                 wr_hit;
  logic                 rd_hit;

`ifdef RAM_CMD_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic                 wr_vld_q;
  logic                 rd_vld_q;

  // The RAM still holds the last address we sent, so a repeat can skip it.
  assign wr_hit = wr_vld_q && (wr_addr_q == req_addr);
  assign rd_hit = rd_vld_q && (rd_addr_q == req_addr);
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif

  // Ready is decoded from state; held low while reset is applied.
  assign req_ready = (state == IDLE) && !rst;

  ram_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == RD_CMD),
    .en     (state == WAIT_RSP),
    .expired(tmo_expired)
  );

  // Sequencer: each transition registers the command word for the next state,
  // so ram_din/ram_rx_valid line up with the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wdata_q      <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
`ifdef RAM_CMD_ADDR_CACHE_EN
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_vld_q     <= 1'b0;
      rd_vld_q     <= 1'b0;
`endif
    end else begin
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wdata_q <= req_wdata;
            ram_rx_valid <= 1'b1;
            if (req_wr) begin
              if (wr_hit) begin
                state   <= WR_DATA;
                ram_din <= {OP_WDATA, req_wdata};
              end else begin
                state   <= WR_ADDR;
                ram_din <= {OP_WADDR, req_addr};
`ifdef RAM_CMD_ADDR_CACHE_EN
                wr_addr_q <= req_addr;
                wr_vld_q  <= 1'b1;
`endif
              end
            end else begin
              if (rd_hit) begin
                state   <= RD_CMD;
                ram_din <= {OP_READ, {ADDR_SIZE{1'b0}}};
              end else begin
                state   <= RD_ADDR;
                ram_din <= {OP_RADDR, req_addr};
`ifdef RAM_CMD_ADDR_CACHE_EN
                rd_addr_q <= req_addr;
                rd_vld_q  <= 1'b1;
`endif
              end
            end
          end
        end
        WR_ADDR: begin
          state        <= WR_DATA;
          ram_din      <= {OP_WDATA, wdata_q};
          ram_rx_valid <= 1'b1;
        end
        WR_DATA: state <= IDLE;
        RD_ADDR: begin
          state        <= RD_CMD;
          ram_din      <= {OP_READ, {ADDR_SIZE{1'b0}}};
          ram_rx_valid <= 1'b1;
        end
        RD_CMD: state <= WAIT_RSP;
        WAIT_RSP: begin
          // Data arriving on the final wait cycle still counts as success.
          if (ram_tx_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_dout;
            rsp_err   <= 1'b0;
          end else if (tmo_expired) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master with a behavioural 1-cycle-latency RAM.
module tb_ram_cmd_master;

  localparam int AW  = 8;
  localparam int TMO = 8;
`ifdef RAM_CMD_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [AW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW+1:0] ram_din;
  logic          ram_rx_valid;
  logic [AW-1:0] ram_dout;
  logic          ram_tx_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  // Behavioural RAM: separate write/read address registers, 1-cycle read.
  logic [AW-1:0] mem [256];
  logic [AW-1:0] ram_wa, ram_ra, ram_dout_q;
  logic          ram_tx_q;
  logic          ram_mute = 1'b0;
  logic          stray_tx = 1'b0;

  assign ram_dout     = ram_dout_q;
  assign ram_tx_valid = ram_tx_q | stray_tx;

  always @(posedge clk) begin
    if (rst) begin
      ram_wa <= '0; ram_ra <= '0; ram_dout_q <= '0; ram_tx_q <= 1'b0;
    end else begin
      ram_tx_q <= 1'b0;
      if (ram_rx_valid) begin
        case (ram_din[AW+1:AW])
          2'b00: ram_wa <= ram_din[AW-1:0];
          2'b01: mem[ram_wa] <= ram_din[AW-1:0];
          2'b10: ram_ra <= ram_din[AW-1:0];
          default: if (!ram_mute) begin ram_dout_q <= mem[ram_ra]; ram_tx_q <= 1'b1; end
        endcase
      end
    end
  end

  // Write transaction; entered and left in a cycle where req_ready is high.
  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] d, input bit cached);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_c0 got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
    if (!cached) begin
      checks++; if (ram_din !== {2'b00, a} || ram_rx_valid !== 1'b1) begin failures++; $display("FAIL wr_addr_word got=%h/%b exp=%h/1", ram_din, ram_rx_valid, {2'b00, a}); end
      @(posedge clk); #1;
    end
    checks++; if (ram_din !== {2'b01, d} || ram_rx_valid !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL wr_data_word got=%h/%b rdy=%b exp=%h/1 rdy=0", ram_din, ram_rx_valid, req_ready, {2'b01, d}); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || ram_rx_valid !== 1'b0 || ram_din !== '0) begin failures++; $display("FAIL wr_done rdy=%b rxv=%b din=%h exp rdy=1 rxv=0 din=0", req_ready, ram_rx_valid, ram_din); end
  endtask

  // Read transaction; exp_delta is cycles from the read word to rsp_valid.
  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] exp_d, input bit exp_err, input bit cached);
    int n;
    bit seen;
    int exp_delta;
    exp_delta = exp_err ? TMO + 1 : 2;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = 8'hEE;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rd_ready_c0 got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a;
    if (!cached) begin
      checks++; if (ram_din !== {2'b10, a} || ram_rx_valid !== 1'b1) begin failures++; $display("FAIL rd_addr_word got=%h/%b exp=%h/1", ram_din, ram_rx_valid, {2'b10, a}); end
      @(posedge clk); #1;
    end
    checks++; if (ram_din !== 10'h300 || ram_rx_valid !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL rd_cmd_word got=%h/%b rdy=%b exp=300/1 rdy=0", ram_din, ram_rx_valid, req_ready); end
    seen = 1'b0;
    for (n = 1; n <= TMO + 6; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || n != exp_delta) begin failures++; $display("FAIL rsp_timing seen=%b delta=%0d exp=%0d", seen, n, exp_delta); end
    checks++; if (rsp_rdata !== exp_d || rsp_err !== exp_err) begin failures++; $display("FAIL rsp_data got=%h err=%b exp=%h err=%b", rsp_rdata, rsp_err, exp_d, exp_err); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_done rdy=%b rspv=%b exp rdy=1 rspv=0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%b/%h/%b exp=0/00/0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if (ram_din !== '0 || ram_rx_valid !== 1'b0) begin failures++; $display("FAIL rst_ram got=%h/%b exp=000/0", ram_din, ram_rx_valid); end
    rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write();
    do_write(8'h12, 8'hA5, 1'b0);
  endtask

  task automatic test_read_after_write();
    do_read(8'h12, 8'hA5, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    ram_mute = 1'b1;
    do_read(8'h77, 8'h00, 1'b1, 1'b0);
    ram_mute = 1'b0;
  endtask

  task automatic test_stray();
    stray_tx = 1'b1;
    @(posedge clk); #1;
    stray_tx = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL stray_c1 rspv=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || ram_rx_valid !== 1'b0) begin failures++; $display("FAIL stray_c2 rspv=%b rxv=%b exp 0/0", rsp_valid, ram_rx_valid); end
    do_write(8'h30, 8'h6B, 1'b0);
    do_read(8'h30, 8'h6B, 1'b0, 1'b0);
    do_read(8'h30, 8'h6B, 1'b0, CACHE);
  endtask

  task automatic test_back_to_back();
    do_write(8'h40, 8'h11, 1'b0);
    do_write(8'h40, 8'h22, CACHE);
    do_write(8'h41, 8'h33, 1'b0);
    do_read(8'h40, 8'h22, 1'b0, 1'b0);
    do_read(8'h41, 8'h33, 1'b0, 1'b0);
    do_read(8'h12, 8'hA5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    bit bad;
    ram_mute = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || ram_rx_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL midrst_in rspv=%b rxv=%b rdy=%b exp 0/0/0", rsp_valid, ram_rx_valid, req_ready); end
    rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    bad = 1'b0;
    for (int i = 0; i < TMO + 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || ram_rx_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL midrst_quiet got=activity exp=none"); end
    ram_mute = 1'b0;
    do_write(8'h21, 8'h3C, 1'b0);
    do_read(8'h21, 8'h3C, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_after_write();
    test_timeout();
    test_stray();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
